// File: rtl/iddrx4_align_pkg.sv
// Shared types and sizing for the x4 DDR gearbox word-alignment controller.
package iddrx4_align_pkg;

   // Default training word; all eight rotations of it are distinct.
   localparam logic [7:0] DEFAULT_PATTERN = 8'h1E;

   // Counter widths sized to the legal parameter ranges.
   localparam int unsigned SETTLE_W = 4;   // SETTLE_CYC 1..15
   localparam int unsigned MATCH_W  = 8;   // MATCH_CNT 1..255
   localparam int unsigned SLIP_W   = 4;   // MAX_SLIPS 1..15, SLIP_CNT saturates at 15
   localparam int unsigned ERR_W    = 4;   // post-lock consecutive error count

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_SLIP,
      ST_LOCKED,
      ST_FAILED
   } state_t;

endpackage

// File: rtl/iddrx4_align_cmp.sv
// Registered training-word compare with consecutive match counter.
// Optional post-lock error counter enabled by `LOCK_MON_EN.
module iddrx4_align_cmp
   import iddrx4_align_pkg::*;
#(
   parameter logic [7:0]  PATTERN   = DEFAULT_PATTERN,
   parameter int unsigned MATCH_CNT = 8
`ifdef LOCK_MON_EN
   , parameter int unsigned ERR_LIMIT = 4
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic       miss,
   output logic       hit
`ifdef LOCK_MON_EN
   , output logic     err_hit
`endif
);

   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic               miss_q, miss_d;
`ifdef LOCK_MON_EN
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
`endif

   // Next-value logic: a match extends the run, any mismatch restarts it.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      match_cnt_d = match_cnt_q;
      miss_d      = miss_q;
`ifdef LOCK_MON_EN
      err_cnt_d   = err_cnt_q;
`endif
      if (clr) begin
         match_cnt_d = '0;
         miss_d      = 1'b0;
`ifdef LOCK_MON_EN
         err_cnt_d   = '0;
`endif
      end else if (en) begin
         if (data == PATTERN) begin
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
            miss_d = 1'b0;
`ifdef LOCK_MON_EN
            err_cnt_d = '0;
`endif
         end else begin
            match_cnt_d = '0;
            miss_d      = 1'b1;
`ifdef LOCK_MON_EN
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
`endif
         end
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (rst) begin
         match_cnt_q <= '0;
         miss_q      <= 1'b0;
`ifdef LOCK_MON_EN
         err_cnt_q   <= '0;
`endif
      end else begin
         match_cnt_q <= match_cnt_d;
         miss_q      <= miss_d;
`ifdef LOCK_MON_EN
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   assign miss = miss_q;
   assign hit  = (match_cnt_q >= MATCH_W'(MATCH_CNT));
`ifdef LOCK_MON_EN
   assign err_hit = (err_cnt_q >= ERR_W'(ERR_LIMIT));
`endif

endmodule

// File: rtl/iddrx4_align_ctrl.sv
// Word-alignment controller for one x4 DDR gearbox lane.
// Issues ALIGNWD slips until the training word is seen MATCH_CNT times in a row.
// Define `LOCK_MON_EN to keep monitoring RXDATA after lock and realign on errors.
module iddrx4_align_ctrl
   import iddrx4_align_pkg::*;
#(
   parameter logic [7:0]  PATTERN    = DEFAULT_PATTERN,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned MATCH_CNT  = 8,
   parameter int unsigned MAX_SLIPS  = 8
`ifdef LOCK_MON_EN
   , parameter int unsigned ERR_LIMIT = 4
`endif
) (
   input  logic              SCLK,
   input  logic              RST,
   input  logic              START,
   input  logic [7:0]        RXDATA,
   output logic              ALIGNWD,
   output logic              BUSY,
   output logic              LOCKED,
   output logic              FAIL,
   output logic [SLIP_W-1:0] SLIP_CNT
);

   state_t              state_q, state_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
   logic                alignwd_q, alignwd_d;
   logic                busy_q, busy_d;
   logic                locked_q, locked_d;
   logic                fail_q, fail_d;

   logic cmp_en, cmp_miss, cmp_hit;
`ifdef LOCK_MON_EN
   logic cmp_err_hit;
   assign cmp_en = (state_q == ST_CHECK) || (state_q == ST_LOCKED);
`else
   assign cmp_en = (state_q == ST_CHECK);
`endif

   iddrx4_align_cmp #(
      .PATTERN   (PATTERN),
      .MATCH_CNT (MATCH_CNT)
`ifdef LOCK_MON_EN
      , .ERR_LIMIT (ERR_LIMIT)
`endif
   ) u_cmp (
      .clk     (SCLK),
      .rst     (RST),
      .clr     (!cmp_en),
      .en      (cmp_en),
      .data    (RXDATA),
      .miss    (cmp_miss),
      .hit     (cmp_hit)
`ifdef LOCK_MON_EN
      , .err_hit (cmp_err_hit)
`endif
   );

   // State, counter and registered-output flops.
   always_ff @(posedge SCLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         slip_cnt_q   <= '0;
         alignwd_q    <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         alignwd_q    <= alignwd_d;
         busy_q       <= busy_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      slip_cnt_d   = slip_cnt_q;
      unique case (state_q)
         ST_IDLE, ST_FAILED: begin
            if (START) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = SETTLE_W'(SETTLE_CYC);
               slip_cnt_d   = '0;
            end
         end
         ST_SETTLE: begin
            settle_cnt_d = settle_cnt_q - 1'b1;
            if (settle_cnt_q <= SETTLE_W'(1)) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (cmp_miss) begin
               if (slip_cnt_q < SLIP_W'(MAX_SLIPS)) begin
                  state_d = ST_SLIP;
                  if (slip_cnt_q != '1) slip_cnt_d = slip_cnt_q + 1'b1;
               end else begin
                  state_d = ST_FAILED;
               end
            end else if (cmp_hit) begin
               state_d = ST_LOCKED;
            end
         end
         ST_SLIP: begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_W'(SETTLE_CYC);
         end
         ST_LOCKED: begin
`ifdef LOCK_MON_EN
            if (START || cmp_err_hit) begin
`else
            if (START) begin
`endif
               state_d      = ST_SETTLE;
               settle_cnt_d = SETTLE_W'(SETTLE_CYC);
               slip_cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the next state so every output is a flop.
   always_comb begin
      alignwd_d = (state_d == ST_SLIP);
      busy_d    = (state_d == ST_SETTLE) || (state_d == ST_CHECK) || (state_d == ST_SLIP);
      locked_d  = (state_d == ST_LOCKED);
      fail_d    = (state_d == ST_FAILED);
   end

   assign ALIGNWD  = alignwd_q;
   assign BUSY     = busy_q;
   assign LOCKED   = locked_q;
   assign FAIL     = fail_q;
   assign SLIP_CNT = slip_cnt_q;

endmodule

// File: tb/tb_iddrx4_align_ctrl.sv
// Self-checking bench for iddrx4_align_ctrl with a rotating-gearbox model.
// Honours `LOCK_MON_EN in the same way as the design.
module tb_iddrx4_align_ctrl;

   localparam logic [7:0] PAT        = 8'h1E;
   localparam int         SETTLE_CYC = 4;

   logic       SCLK = 1'b0;
   logic       RST  = 1'b1;
   logic       START = 1'b0;
   logic [7:0] RXDATA;
   logic       ALIGNWD, BUSY, LOCKED, FAIL;
   logic [3:0] SLIP_CNT;

   iddrx4_align_ctrl dut (
      .SCLK     (SCLK),
      .RST      (RST),
      .START    (START),
      .RXDATA   (RXDATA),
      .ALIGNWD  (ALIGNWD),
      .BUSY     (BUSY),
      .LOCKED   (LOCKED),
      .FAIL     (FAIL),
      .SLIP_CNT (SLIP_CNT)
   );

   always #5 SCLK = ~SCLK;

   // Gearbox model: output is PAT rotated left by k; each slip pulse advances k.
   logic [2:0] k_q    = 3'd0;
   logic [2:0] k_init = 3'd0;
   logic       k_load = 1'b0;
   logic       bad    = 1'b0;

   function automatic logic [7:0] rotl(input logic [7:0] v, input logic [2:0] n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

   always @(posedge SCLK) begin
      if (k_load)       k_q <= k_init;
      else if (ALIGNWD) k_q <= k_q + 3'd1;
   end

   assign RXDATA = bad ? 8'h00 : rotl(PAT, k_q);

   // Pulse monitor: counts pulses, over-wide pulses and too-short gaps.
   int  pulse_total = 0;
   int  wide_cnt    = 0;
   int  gap_viol    = 0;
   int  gap         = 1000;
   logic prev_al    = 1'b0;

   always @(negedge SCLK) begin
      if (ALIGNWD) begin
         if (prev_al) wide_cnt = wide_cnt + 1;
         else begin
            if (gap < SETTLE_CYC + 1) gap_viol = gap_viol + 1;
            pulse_total = pulse_total + 1;
         end
         gap = 0;
      end else begin
         gap = gap + 1;
      end
      prev_al = ALIGNWD;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec = n_vec + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Load gearbox offset and pulse START; returns at the negedge after START is sampled.
   task automatic start_align(input logic [2:0] k);
      @(negedge SCLK);
      k_init = k;
      k_load = 1'b1;
      START  = 1'b1;
      @(posedge SCLK);
      @(negedge SCLK);
      START  = 1'b0;
      k_load = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge SCLK);
         if (!BUSY) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Offset 0: LOCKED exactly 13 edges after START is sampled, no slips.
   task automatic run_latency(input string tag);
      int p0;
      p0 = pulse_total;
      start_align(3'd0);
      check({tag, " locked_after_start"}, LOCKED, 0);
      check({tag, " busy_after_start"}, BUSY, 1);
      check({tag, " fail_after_start"}, FAIL, 0);
      for (int n = 1; n <= 13; n++) begin
         @(negedge SCLK);
         if (n == 12) check({tag, " locked_edge12"}, LOCKED, 0);
         if (n == 13) begin
            check({tag, " locked_edge13"}, LOCKED, 1);
            check({tag, " busy_edge13"}, BUSY, 0);
            check({tag, " slip_cnt"}, SLIP_CNT, 0);
            check({tag, " pulses"}, pulse_total - p0, 0);
         end
      end
   endtask

   typedef struct {
      logic [2:0] k;
      bit         stuck;
      bit         exp_locked;
      bit         exp_fail;
      int         exp_slips;
   } vec_t;

   vec_t tbl[5];

   initial begin
      bit ok;
      int p0, w0, g0;

      tbl[0] = '{k: 3'd0, stuck: 1'b0, exp_locked: 1'b1, exp_fail: 1'b0, exp_slips: 0};
      tbl[1] = '{k: 3'd5, stuck: 1'b0, exp_locked: 1'b1, exp_fail: 1'b0, exp_slips: 3};
      tbl[2] = '{k: 3'd7, stuck: 1'b0, exp_locked: 1'b1, exp_fail: 1'b0, exp_slips: 1};
      tbl[3] = '{k: 3'd1, stuck: 1'b0, exp_locked: 1'b1, exp_fail: 1'b0, exp_slips: 7};
      tbl[4] = '{k: 3'd0, stuck: 1'b1, exp_locked: 1'b0, exp_fail: 1'b1, exp_slips: 8};

      // Reset state
      repeat (3) @(negedge SCLK);
      check("rst alignwd", ALIGNWD, 0);
      check("rst busy", BUSY, 0);
      check("rst locked", LOCKED, 0);
      check("rst fail", FAIL, 0);
      check("rst slip_cnt", SLIP_CNT, 0);
      RST = 1'b0;
      @(negedge SCLK);

      // Exact lock latency from IDLE
      run_latency("idle_start");

      // Restart while locked: LOCKED drops on the next edge and relocks
      run_latency("relock");

      // Table: offsets and stuck data
      foreach (tbl[i]) begin
         bad = tbl[i].stuck;
         p0 = pulse_total;
         w0 = wide_cnt;
         g0 = gap_viol;
         start_align(tbl[i].k);
         wait_idle(400, ok);
         check($sformatf("vec%0d done", i), ok, 1);
         check($sformatf("vec%0d locked", i), LOCKED, tbl[i].exp_locked);
         check($sformatf("vec%0d fail_out", i), FAIL, tbl[i].exp_fail);
         check($sformatf("vec%0d slip_cnt", i), SLIP_CNT, tbl[i].exp_slips);
         check($sformatf("vec%0d pulses", i), pulse_total - p0, tbl[i].exp_slips);
         check($sformatf("vec%0d wide_pulses", i), wide_cnt - w0, 0);
         check($sformatf("vec%0d short_gaps", i), gap_viol - g0, 0);
         bad = 1'b0;
      end

      // Restart from the failed state clears the fail flag
      run_latency("from_failed");
      check("from_failed fail_out", FAIL, 0);

      // Reset during a slip cycle
      start_align(3'd3);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge SCLK);
         if (ALIGNWD) begin
            ok = 1'b1;
            break;
         end
      end
      check("slip seen", ok, 1);
      #1 RST = 1'b1;
      #1;
      check("mid_rst alignwd", ALIGNWD, 0);
      check("mid_rst busy", BUSY, 0);
      check("mid_rst locked", LOCKED, 0);
      check("mid_rst fail", FAIL, 0);
      check("mid_rst slip_cnt", SLIP_CNT, 0);
      @(negedge SCLK);
      RST = 1'b0;
      @(negedge SCLK);
      run_latency("post_rst");

`ifdef LOCK_MON_EN
      // Three bad words then a good one: lock holds
      @(negedge SCLK);
      bad = 1'b1;
      repeat (3) @(negedge SCLK);
      bad = 1'b0;
      repeat (4) @(negedge SCLK);
      check("mon 3bad locked", LOCKED, 1);
      check("mon 3bad busy", BUSY, 0);
      // Four bad words: lock drops and realignment starts
      bad = 1'b1;
      repeat (4) @(negedge SCLK);
      bad = 1'b0;
      repeat (2) @(negedge SCLK);
      check("mon 4bad locked", LOCKED, 0);
      check("mon 4bad busy", BUSY, 1);
      check("mon 4bad slip_cnt", SLIP_CNT, 0);
      wait_idle(100, ok);
      check("mon realign done", ok, 1);
      check("mon realign locked", LOCKED, 1);
`else
      // Without the monitor, lock is sticky through bad data
      @(negedge SCLK);
      bad = 1'b1;
      repeat (6) @(negedge SCLK);
      bad = 1'b0;
      repeat (2) @(negedge SCLK);
      check("sticky locked", LOCKED, 1);
      check("sticky busy", BUSY, 0);
`endif

      // START while busy is ignored: lock still arrives on schedule
      start_align(3'd0);
      repeat (2) @(negedge SCLK);
      START = 1'b1;
      @(negedge SCLK);
      START = 1'b0;
      repeat (10) @(negedge SCLK);
      check("busy_start locked", LOCKED, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
